sccb_reg_responder: RTL and testbench
=====================================

// Module: sccb_reg_responder
// PURPOSE
// SCCB/I2C target (responder) on the camera control bus: the far end of our register-init master.
// It decodes START/STOP, matches a 7-bit device address and accepts frames of 16-bit register
// address + 8-bit data bytes. Each accepted data byte is emitted as a one-cycle register-write strobe.
// It also answers reads from a caller-supplied register source.
// Use: camera model in benches, and register shadow capture on the FPGA.
// PARAMETERS
// DEV_ADDR     7'h3C  7-bit target address matched in the address byte
// SYNC_STAGES  2      flops in the scl_i/sda_i synchronizers (>=2)
// PORTS
// clk_in        in   1   system clock; scl_i/sda_i are oversampled on it (>=8x SCL)
// rst_in        in   1   synchronous, active-high reset
// scl_i         in   1   SCL pin input
// sda_i         in   1   SDA pin input
// sda_o         out  1   SDA drive value (0 when pulling low)
// sda_t         out  1   SDA tristate: 1 = released, 0 = driving sda_o
// reg_wr_valid  out  1   one-cycle strobe: a data byte was accepted
// reg_wr_addr   out  16  register address for the strobe
// reg_wr_data   out  8   data byte for the strobe
// rd_addr       out  16  current register pointer, driven continuously
// rd_data       in   8   register value at rd_addr; must be valid <=2 clk_in after rd_addr changes
// busy          out  1   high from matched address byte until STOP, or until IDLE via NACK
// BEHAVIOUR
// - Reset values: sda_o=1, sda_t=1, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0,
//   rd_addr=0 (pointer), busy=0, state=IDLE. Reset mid-frame releases SDA on the next cycle.
// - Bus inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals.
//   A rise is sampled by the cycle after it, and that cycle is "posedge".
// - START = sda falls while scl high. STOP = sda rises while scl high.
//   Both are honoured from any state. START (incl. repeated) -> bit_cnt=0, go ADDR.
//   STOP -> release SDA, go IDLE.
// - Data bits are shifted in MSB first on SCL posedge. bit_cnt is 0..7.
// - The responder drives SDA only on SCL negedge, and only while SCL is low.
// - States:
//   IDLE   -> ADDR on START.
//   ADDR   after 8 bits: if [7:1]==DEV_ADDR, ACK, busy=1, then
//          R/W=0 -> REG_HI, R/W=1 -> RD_BYTE. Mismatch: no ACK, go IDLE.
//   REG_HI ACK, capture ptr_hi, -> REG_LO.
//   REG_LO ACK, pointer <= {ptr_hi, byte}, -> WR_DATA.
//   WR_DATA ACK. Pulse reg_wr_valid with addr=pointer, data=byte on the cycle after the
//          8th posedge. Then pointer+1 and stay in WR_DATA.
//   RD_BYTE on each negedge, drive rd_data[7-bit_cnt]. Sample rd_data on the ACK-slot negedge
//          (first byte: ADDR-ACK end). After 8 bits, release SDA and sample the master bit
//          on the 9th posedge: 0 -> pointer+1, stay; 1 (NACK) -> IDLE.
// - ACK = sda_o=0, sda_t=0 from the negedge after bit 8 until the next negedge, then release.
//   A released 1 is always sda_o=1, sda_t=1.
// - Pointer arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000. No write is issued for a frame
//   that ends (STOP or START) before the data byte completes. A pointer set by REG_LO
//   persists across STOP, so "write addr, repeated START, read" works.
// - reg_wr_valid has no backpressure and no clock stretching. The consumer accepts every strobe.
// - sda_i is never sampled during a byte this block drives. ADDR/REG bits are never driven.
// TESTING
// 1 Write 0x3C<<1|0, 0x30,0x08, 0x42, STOP -> ACK on all 4 bytes;
//   one strobe addr=16'h3008 data=8'h42; busy low after STOP.
// 2 Burst: addr 0x4300, data 0x11,0x22,0x33 -> three strobes at 0x4300/0x4301/0x4302; rd_addr=0x4303.
// 3 Addr 0x21 (wrong) + 3 bytes -> sda_t stays 1 throughout; no strobe; busy stays 0.
// 4 Write ptr 0x300A, repeated START, read with rd_data=0x56, master ACK then NACK
//   -> bytes 0x56 @0x300A and rd_data @0x300B; IDLE after NACK, SDA released.
// 5 Pointer 0xFFFF, write 0xAA,0xBB -> strobes @0xFFFF and @0x0000.
// 6 STOP after REG_HI; rst_in during ACK slot -> no strobe; SDA released within 1 cycle;
//   all outputs at reset values.

Source files
------------

// File: rtl/sccb_reg_responder.sv
// SCCB/I2C register target: matches DEV_ADDR, takes a 16-bit register pointer
// followed by data bytes (one write strobe per byte), and serves reads from rd_data.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | bus idle or frame not for us; only START is honoured
// S_ADDR     | shifting in the address byte
// S_REG_HI   | shifting in the pointer high byte
// S_REG_LO   | shifting in the pointer low byte
// S_WR_DATA  | shifting in data bytes, one strobe per byte, pointer auto-increments
// S_RD_BYTE  | driving rd_data bits out, master ACK/NACK on the 9th clock
module sccb_reg_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        reg_wr_valid,
  output logic [15:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA, S_RD_BYTE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        slot_q, slot_d;   // inside the 9th (ACK) bit period
  logic        open_q, open_d;   // ACK-slot negedge already seen
  logic        rnw_q, rnw_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  ptr_hi_q, ptr_hi_d;
  logic [7:0]  rd_sr_q, rd_sr_d;
  logic        sda_o_q, sda_o_d, sda_t_q, sda_t_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic [7:0]  byte_in;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};

  // Bus synchronizers and one-cycle-delayed copies for edge/condition detection
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      slot_q     <= 1'b0;
      open_q     <= 1'b0;
      rnw_q      <= 1'b0;
      ptr_q      <= 16'd0;
      ptr_hi_q   <= 8'd0;
      rd_sr_q    <= 8'd0;
      sda_o_q    <= 1'b1;
      sda_t_q    <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      slot_q     <= slot_d;
      open_q     <= open_d;
      rnw_q      <= rnw_d;
      ptr_q      <= ptr_d;
      ptr_hi_q   <= ptr_hi_d;
      rd_sr_q    <= rd_sr_d;
      sda_o_q    <= sda_o_d;
      sda_t_q    <= sda_t_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: bus conditions first, then per-bit work on SCL edges
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    slot_d     = slot_q;
    open_d     = open_q;
    rnw_d      = rnw_q;
    ptr_d      = ptr_q;
    ptr_hi_d   = ptr_hi_q;
    rd_sr_d    = rd_sr_q;
    sda_o_d    = sda_o_q;
    sda_t_d    = sda_t_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      slot_d    = 1'b0;
      open_d    = 1'b0;
      sda_o_d   = 1'b1;
      sda_t_d   = 1'b1;
    end else if (stop_det) begin
      state_d = S_IDLE;
      slot_d  = 1'b0;
      open_d  = 1'b0;
      busy_d  = 1'b0;
      sda_o_d = 1'b1;
      sda_t_d = 1'b1;
    end else if (state_q != S_IDLE) begin
      if (scl_rise) begin
        if (!slot_q) begin
          if (state_q != S_RD_BYTE) shift_d = byte_in;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            slot_d    = 1'b1;
            case (state_q)
              S_ADDR: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  rnw_d  = byte_in[0];
                end else begin
                  state_d = S_IDLE;
                  slot_d  = 1'b0;
                  busy_d  = 1'b0;
                end
              end
              S_REG_HI: ptr_hi_d = byte_in;
              S_REG_LO: ptr_d = {ptr_hi_q, byte_in};
              S_WR_DATA: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 16'd1;
              end
              default: ;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (state_q == S_RD_BYTE && open_q) begin
          // master's acknowledge bit for the byte we just sent
          if (sda_s) begin
            state_d = S_IDLE;
            slot_d  = 1'b0;
            open_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            ptr_d = ptr_q + 16'd1;
          end
        end
      end else if (scl_fall) begin
        if (slot_q && !open_q) begin
          open_d = 1'b1;
          if (state_q == S_RD_BYTE) begin
            sda_o_d = 1'b1;
            sda_t_d = 1'b1;
          end else begin
            sda_o_d = 1'b0;
            sda_t_d = 1'b0;
          end
        end else if (slot_q) begin
          slot_d  = 1'b0;
          open_d  = 1'b0;
          sda_o_d = 1'b1;
          sda_t_d = 1'b1;
          case (state_q)
            S_ADDR: begin
              if (rnw_q) begin
                state_d = S_RD_BYTE;
                rd_sr_d = rd_data;
                sda_o_d = rd_data[7];
                sda_t_d = 1'b0;
              end else begin
                state_d = S_REG_HI;
              end
            end
            S_REG_HI: state_d = S_REG_LO;
            S_REG_LO: state_d = S_WR_DATA;
            S_RD_BYTE: begin
              rd_sr_d = rd_data;
              sda_o_d = rd_data[7];
              sda_t_d = 1'b0;
            end
            default: ;
          endcase
        end else if (state_q == S_RD_BYTE) begin
          sda_o_d = rd_sr_q[3'd7 - bit_cnt_q];
          sda_t_d = 1'b0;
        end
      end
    end
  end

  assign sda_o        = sda_o_q;
  assign sda_t        = sda_t_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign rd_addr      = ptr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sccb_reg_responder.sv
// Directed bench for sccb_reg_responder: bit-banged SCCB master, open-drain bus model,
// strobe capture queue and a register source driven from rd_addr.
module tb_sccb_reg_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_o, sda_t, reg_wr_valid, busy;
  logic [15:0] reg_wr_addr, rd_addr;
  logic [7:0]  reg_wr_data, rd_data;
  logic        sda_bus;

  int errors = 0;
  int checks = 0;

  logic [15:0] st_addr[$];
  logic [7:0]  st_data[$];
  int          drive_cnt = 0;
  int          busy_cnt  = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_t | sda_o);
  assign rd_data = (rd_addr == 16'h300A) ? 8'h56 : (rd_addr[7:0] ^ 8'hA5);

  sccb_reg_responder #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk_in(clk), .rst_in(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t), .reg_wr_valid(reg_wr_valid),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Capture write strobes and activity counters
  always @(posedge clk) begin
    if (reg_wr_valid) begin
      st_addr.push_back(reg_wr_addr);
      st_data.push_back(reg_wr_data);
    end
    if (!sda_t) drive_cnt <= drive_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_strobe(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    if (idx < st_addr.size()) begin
      chk({tag, " addr"}, 32'(st_addr[idx]), 32'(a));
      chk({tag, " data"}, 32'(st_data[idx]), 32'(d));
    end else begin
      chk({tag, " present"}, 32'(st_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic wq();
    repeat (4) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
    wq();
  endtask

  task automatic send8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
    end
  endtask

  // ack = 1 when the responder pulled SDA low during the 9th clock
  task automatic wbyte(input logic [7:0] b, output logic ack);
    send8(b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = ~sda_bus;
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl_m = 1'b1; wq();
      b[i] = sda_bus;
      wq();
      scl_m = 1'b0;
    end
    wq();
    sda_m = mack; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
    sda_m = 1'b1;
  endtask

  initial begin
    logic       a;
    logic       acks;
    logic [7:0] rb;
    int         base, dsnap, bsnap;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset sda_o", 32'(sda_o), 32'h1);
    chk("reset sda_t", 32'(sda_t), 32'h1);
    chk("reset valid", 32'(reg_wr_valid), 32'h0);
    chk("reset rd_addr", 32'(rd_addr), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);

    // 1: single write 0x3008 <= 0x42
    base = st_addr.size();
    i2c_start();
    wbyte(8'h78, a); chk("t1 ack addr", 32'(a), 32'h1);
    chk("t1 busy mid", 32'(busy), 32'h1);
    wbyte(8'h30, a); chk("t1 ack hi", 32'(a), 32'h1);
    wbyte(8'h08, a); chk("t1 ack lo", 32'(a), 32'h1);
    wbyte(8'h42, a); chk("t1 ack data", 32'(a), 32'h1);
    i2c_stop();
    chk("t1 strobes", 32'(st_addr.size() - base), 32'd1);
    chk_strobe("t1 s0", base, 16'h3008, 8'h42);
    chk("t1 busy after stop", 32'(busy), 32'h0);

    // 2: burst at 0x4300
    base = st_addr.size();
    acks = 1'b1;
    i2c_start();
    wbyte(8'h78, a); acks &= a;
    wbyte(8'h43, a); acks &= a;
    wbyte(8'h00, a); acks &= a;
    wbyte(8'h11, a); acks &= a;
    wbyte(8'h22, a); acks &= a;
    wbyte(8'h33, a); acks &= a;
    i2c_stop();
    chk("t2 all acked", 32'(acks), 32'h1);
    chk("t2 strobes", 32'(st_addr.size() - base), 32'd3);
    chk_strobe("t2 s0", base, 16'h4300, 8'h11);
    chk_strobe("t2 s1", base + 1, 16'h4301, 8'h22);
    chk_strobe("t2 s2", base + 2, 16'h4302, 8'h33);
    chk("t2 rd_addr", 32'(rd_addr), 32'h4303);

    // 3: wrong device address 0x21
    base = st_addr.size();
    dsnap = drive_cnt;
    bsnap = busy_cnt;
    i2c_start();
    wbyte(8'h42, a); chk("t3 nack addr", 32'(a), 32'h0);
    wbyte(8'h30, a);
    wbyte(8'h08, a);
    wbyte(8'h55, a);
    i2c_stop();
    chk("t3 sda never driven", 32'(drive_cnt - dsnap), 32'd0);
    chk("t3 busy never high", 32'(busy_cnt - bsnap), 32'd0);
    chk("t3 strobes", 32'(st_addr.size() - base), 32'd0);

    // 4: set pointer 0x300A, repeated START, read two bytes
    base = st_addr.size();
    i2c_start();
    wbyte(8'h78, a);
    wbyte(8'h30, a);
    wbyte(8'h0A, a);
    i2c_start();
    wbyte(8'h79, a); chk("t4 ack read addr", 32'(a), 32'h1);
    chk("t4 ptr", 32'(rd_addr), 32'h300A);
    rbyte(1'b0, rb); chk("t4 byte0", 32'(rb), 32'h56);
    rbyte(1'b1, rb); chk("t4 byte1", 32'(rb), 32'hAE);
    chk("t4 busy after nack", 32'(busy), 32'h0);
    chk("t4 sda released", 32'(sda_t), 32'h1);
    chk("t4 rd_addr", 32'(rd_addr), 32'h300B);
    i2c_stop();
    chk("t4 no strobes", 32'(st_addr.size() - base), 32'd0);

    // 5: pointer wrap
    base = st_addr.size();
    i2c_start();
    wbyte(8'h78, a);
    wbyte(8'hFF, a);
    wbyte(8'hFF, a);
    wbyte(8'hAA, a);
    wbyte(8'hBB, a);
    i2c_stop();
    chk("t5 strobes", 32'(st_addr.size() - base), 32'd2);
    chk_strobe("t5 s0", base, 16'hFFFF, 8'hAA);
    chk_strobe("t5 s1", base + 1, 16'h0000, 8'hBB);
    chk("t5 rd_addr", 32'(rd_addr), 32'h0001);

    // 6: STOP after REG_HI, then reset during REG_LO ACK slot
    base = st_addr.size();
    i2c_start();
    wbyte(8'h78, a);
    wbyte(8'h12, a);
    i2c_stop();
    chk("t6 busy after stop", 32'(busy), 32'h0);
    i2c_start();
    wbyte(8'h78, a);
    wbyte(8'h12, a);
    send8(8'h34);
    sda_m = 1'b1; wq();
    chk("t6 ack driven", 32'(sda_t), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6 sda_t released", 32'(sda_t), 32'h1);
    chk("t6 sda_o released", 32'(sda_o), 32'h1);
    @(negedge clk);
    chk("t6 valid", 32'(reg_wr_valid), 32'h0);
    chk("t6 wr_addr", 32'(reg_wr_addr), 32'h0);
    chk("t6 wr_data", 32'(reg_wr_data), 32'h0);
    chk("t6 rd_addr", 32'(rd_addr), 32'h0);
    chk("t6 busy", 32'(busy), 32'h0);
    rst = 1'b0;
    scl_m = 1'b1; wq(); wq();
    chk("t6 strobes", 32'(st_addr.size() - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
